// File: rtl/cpu_pkg.sv
// cpu_pkg: shared hazard-control FSM state encoding and timeout default.
package cpu_pkg;
    typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load in EX.
module load_use_detect (
    input  logic       reg_write_i,
    input  logic       mem_to_reg_i,
    input  logic [4:0] write_reg_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic       hazard_o
);
    assign hazard_o = reg_write_i & mem_to_reg_i & (write_reg_i != 5'd0) &
                      ((write_reg_i == rs_i) | (write_reg_i == rt_i));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with data-memory wait FSM and timeout.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        regWrite_EX,
    input  logic        memToReg_EX,
    input  logic [4:0]  writeReg_EX,
    input  logic        branchTaken_EX,
    input  logic        memRead_MEM,
    input  logic        memWrite_MEM,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        stall_EX,
    output logic        stall_MEM,
    output logic        flush_ID,
    output logic        flush_EX,
    output logic        bubble_WB,
    output logic        mem_error,
    output logic [15:0] stall_count
);
    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;
    logic        load_use, mem_acc, in_wait, timeout, mem_stall;

    load_use_detect u_lu (
        .reg_write_i  (regWrite_EX),
        .mem_to_reg_i (memToReg_EX),
        .write_reg_i  (writeReg_EX),
        .rs_i         (rs_ID),
        .rt_i         (rt_ID),
        .hazard_o     (load_use)
    );

    always_comb begin
        mem_acc   = memRead_MEM | memWrite_MEM;
        in_wait   = state_q == MEM_WAIT;
        timeout   = in_wait & ~mem_ready & (wait_q == 8'(TIMEOUT_CYCLES - 1));
        mem_stall = in_wait & ~mem_ready & ~timeout;
        // Outputs are forced low while reset is held, even mid-wait.
        mem_req   = ~reset & (in_wait | mem_acc);
        stall_MEM = ~reset & mem_stall;
        stall_EX  = ~reset & mem_stall;
        stall_IF  = ~reset & (mem_stall | (~branchTaken_EX & load_use));
        stall_ID  = ~reset & (mem_stall | (~branchTaken_EX & load_use));
        flush_ID  = ~reset & ~mem_stall & branchTaken_EX;
        flush_EX  = ~reset & ~mem_stall & (branchTaken_EX | load_use);
        bubble_WB = ~reset & (mem_stall | timeout);
        mem_error = err_q;
        stall_count = count_q;
        state_d   = in_wait ? (mem_stall ? MEM_WAIT : IDLE)
                            : ((mem_acc & ~mem_ready) ? MEM_WAIT : IDLE);
        wait_d    = in_wait ? wait_q + 8'd1 : 8'd0;
        err_d     = err_q | timeout;
        count_d   = (mem_stall && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a cycle-level model.
module tb_hazard_ctrl;
    localparam int TMO = 4;
    logic        clk = 1'b0, reset = 1'b1;
    logic [4:0]  rs_ID = '0, rt_ID = '0, writeReg_EX = '0;
    logic        regWrite_EX = 0, memToReg_EX = 0, branchTaken_EX = 0;
    logic        memRead_MEM = 0, memWrite_MEM = 0, mem_ready = 0;
    logic        mem_req, stall_IF, stall_ID, stall_EX, stall_MEM;
    logic        flush_ID, flush_EX, bubble_WB, mem_error;
    logic [15:0] stall_count;
    logic [24:0] obs;
    int          n_cmp = 0, n_bad = 0;
    bit          m_wait = 0, m_err = 0;
    int          m_n = 0, m_sc = 0;

    hazard_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .regWrite_EX(regWrite_EX), .memToReg_EX(memToReg_EX), .writeReg_EX(writeReg_EX),
        .branchTaken_EX(branchTaken_EX), .memRead_MEM(memRead_MEM), .memWrite_MEM(memWrite_MEM),
        .mem_ready(mem_ready), .mem_req(mem_req), .stall_IF(stall_IF), .stall_ID(stall_ID),
        .stall_EX(stall_EX), .stall_MEM(stall_MEM), .flush_ID(flush_ID), .flush_EX(flush_EX),
        .bubble_WB(bubble_WB), .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;
    assign obs = {mem_req, stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
                  bubble_WB, mem_error, stall_count};

    // Expected outputs from the current inputs and the model's view of the memory wait.
    function automatic logic [24:0] expect_out();
        bit lu, ms, tmo, req, s_if, fl_id, fl_ex, bub;
        if (reset) return '0;
        lu    = regWrite_EX && memToReg_EX && writeReg_EX != 0 &&
                (writeReg_EX == rs_ID || writeReg_EX == rt_ID);
        ms    = m_wait && !mem_ready && (m_n + 1 < TMO);
        tmo   = m_wait && !mem_ready && (m_n + 1 == TMO);
        req   = m_wait || memRead_MEM || memWrite_MEM;
        s_if  = ms || (!branchTaken_EX && lu);
        fl_id = !ms && branchTaken_EX;
        fl_ex = !ms && (branchTaken_EX || lu);
        bub   = ms || tmo;
        return {req, s_if, s_if, ms, ms, fl_id, fl_ex, bub, m_err, 16'(m_sc)};
    endfunction

    task automatic model_next();
        if (reset) begin
            m_wait = 0; m_err = 0; m_n = 0; m_sc = 0;
        end else if (m_wait) begin
            if (mem_ready) m_wait = 0;
            else if (m_n + 1 == TMO) begin m_wait = 0; m_err = 1; end
            else begin m_n++; m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc; end
        end else if ((memRead_MEM || memWrite_MEM) && !mem_ready) begin
            m_wait = 1; m_n = 0;
        end
    endtask

    task automatic cyc(output logic [24:0] e, output logic [24:0] o);
        @(negedge clk);
        e = expect_out();
        o = obs;
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit rw, input bit m2r, input logic [4:0] wr,
                          input logic [4:0] rs, input logic [4:0] rt, input bit br);
        regWrite_EX = rw; memToReg_EX = m2r; writeReg_EX = wr;
        rs_ID = rs; rt_ID = rt; branchTaken_EX = br;
    endtask

    task automatic test_reset();
        logic [24:0] e, o;
        #2;
        n_cmp++;
        if (obs !== 25'd0) begin n_bad++; $display("FAIL reset_hold got=%h want=0", obs); end
        @(posedge clk); #1;
        reset = 0;
        model_next();
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_idle got=%h want=%h", o, e); end
    endtask

    task automatic test_mem_wait();
        logic [24:0] e, o;
        memRead_MEM = 1; mem_ready = 0;
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'h80) begin n_bad++; $display("FAIL mw_issue got=%h want=%h", o, e); end
        for (int i = 0; i < 3; i++) begin
            cyc(e, o);
            n_cmp++;
            if (o !== e || o[24:17] !== 8'hF9) begin n_bad++; $display("FAIL mw_stall%0d got=%h want=%h", i, o, e); end
        end
        mem_ready = 1;
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[23:17] !== 7'd0) begin n_bad++; $display("FAIL mw_release got=%h want=%h", o, e); end
        memRead_MEM = 0;
        n_cmp++;
        if (stall_count !== 16'd3) begin n_bad++; $display("FAIL mw_count got=%0d want=3", stall_count); end
    endtask

    task automatic test_load_use();
        logic [24:0] e, o;
        set_ex(1, 1, 5, 5, 0, 0);
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[23:17] !== 7'b1100010) begin n_bad++; $display("FAIL lu_rs got=%h want=%h", o, e); end
        set_ex(1, 1, 5, 6, 6, 0);
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'd0) begin n_bad++; $display("FAIL lu_miss got=%h want=%h", o, e); end
        set_ex(1, 1, 0, 0, 0, 0);
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'd0) begin n_bad++; $display("FAIL lu_zero got=%h want=%h", o, e); end
        set_ex(1, 1, 9, 3, 9, 0);
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lu_rt got=%h want=%h", o, e); end
        set_ex(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_branch_priority();
        logic [24:0] e, o;
        set_ex(1, 1, 7, 7, 1, 1);
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'b00000110) begin n_bad++; $display("FAIL br_over_lu got=%h want=%h", o, e); end
        memWrite_MEM = 1; mem_ready = 0;
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL br_issue got=%h want=%h", o, e); end
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'hF9) begin n_bad++; $display("FAIL mem_over_br got=%h want=%h", o, e); end
        mem_ready = 1;
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL br_release got=%h want=%h", o, e); end
        memWrite_MEM = 0;
        set_ex(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        logic [24:0] e, o;
        memRead_MEM = 1; mem_ready = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            cyc(e, o);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL tmo_cyc%0d got=%h want=%h", i, o, e); end
        end
        n_cmp++;
        if (o[24:17] !== 8'h81) begin n_bad++; $display("FAIL tmo_drop got=%h want=81", o[24:17]); end
        mem_ready = 1;
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[16] !== 1'b1 || o[23:17] !== 7'd0) begin n_bad++; $display("FAIL tmo_sticky got=%h want=%h", o, e); end
        memRead_MEM = 0;
    endtask

    task automatic test_random();
        logic [24:0] e, o;
        for (int i = 0; i < 400; i++) begin
            set_ex(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
            memRead_MEM  = $urandom_range(0, 3) == 0;
            memWrite_MEM = $urandom_range(0, 5) == 0;
            mem_ready    = $urandom_range(0, 2) == 0;
            cyc(e, o);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rand%0d got=%h want=%h", i, o, e); end
        end
        set_ex(0, 0, 0, 0, 0, 0);
        memRead_MEM = 0; memWrite_MEM = 0; mem_ready = 1;
        cyc(e, o);
    endtask

    task automatic test_async_reset();
        logic [24:0] e, o;
        memRead_MEM = 1; mem_ready = 0;
        set_ex(1, 1, 4, 4, 0, 1);
        cyc(e, o);
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL ar_wait1 got=%h want=%h", o, e); end
        #2 reset = 1;
        #1;
        n_cmp++;
        if (obs !== 25'd0) begin n_bad++; $display("FAIL ar_immediate got=%h want=0", obs); end
        model_next();
        @(posedge clk); #1;
        reset = 0;
        memRead_MEM = 0; mem_ready = 0;
        set_ex(0, 0, 0, 0, 0, 0);
        cyc(e, o);
        n_cmp++;
        if (o !== e || o !== 25'd0) begin n_bad++; $display("FAIL ar_idle got=%h want=0", o); end
        memRead_MEM = 1;
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'h80) begin n_bad++; $display("FAIL ar_reissue got=%h want=%h", o, e); end
        cyc(e, o);
        n_cmp++;
        if (o !== e || o[24:17] !== 8'hF9) begin n_bad++; $display("FAIL ar_rewait got=%h want=%h", o, e); end
        mem_ready = 1;
        cyc(e, o);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL ar_release got=%h want=%h", o, e); end
    endtask

    initial begin
        test_reset();
        test_mem_wait();
        test_load_use();
        test_branch_priority();
        test_timeout();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
